// File: rtl/demux_sched.sv
// Round-robin / fixed-select sequencer for a 1:4 demux: holds one word and
// steers it to a channel via one-hot valid, re-steering stalled round-robin words.
module demux_sched #(
  parameter int W   = 8,
  parameter int TMO = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         mode,
  input  logic [1:0]   sel,
  output logic [3:0]   out_valid,
  output logic [W-1:0] out_data,
  input  logic [3:0]   out_ready,
  output logic [1:0]   cur_ch,
  output logic [7:0]   skip_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] TMO_C  = TMO[7:0];
  localparam logic       TMO_EN = (TMO != 0);

  state_t         state_q;
  logic [W-1:0]   data_q;
  logic [1:0]     cur_ch_q;
  logic [1:0]     ptr_q;
  logic [7:0]     timer_q;
  logic [7:0]     skip_q;
  logic           hmode_q;
  logic           done;

  // Only the targeted channel's ready can complete the transfer.
  assign done = out_ready[cur_ch_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cur_ch_q <= 2'd0;
      ptr_q    <= 2'd0;
      timer_q  <= 8'd0;
      skip_q   <= 8'd0;
      hmode_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            hmode_q  <= mode;
            cur_ch_q <= mode ? sel : ptr_q;
            timer_q  <= 8'd0;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (done) begin
            state_q <= IDLE;
            if (!hmode_q) ptr_q <= cur_ch_q + 2'd1;
          end else if (!hmode_q && TMO_EN) begin
            // Completion already lost this cycle, so the timeout may fire.
            if (timer_q == TMO_C) begin
              cur_ch_q <= cur_ch_q + 2'd1;
              timer_q  <= 8'd0;
              if (skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of registered state.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ov
    assign out_valid[gi] = (state_q == HOLD) && (cur_ch_q == 2'(gi));
  end

  assign in_ready = (state_q == IDLE);
  assign out_data = data_q;
  assign cur_ch   = cur_ch_q;
  assign skip_cnt = skip_q;

endmodule
